uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit path.
//   CLK_DIV_DEFAULT : clocks per UART bit (25 MHz / 115200)
//   BAUD_CNT_W      : baud counter width, covers CLK_DIV up to 8191
//   tx_state_e      : transmitter FSM states
package uart_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 217;
    localparam int unsigned BAUD_CNT_W      = 13;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO built from flops, registered occupancy count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push request (ignored while full)
//   wr_data    : data pushed
//   rd_en      : pop request (ignored while empty)
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : combinational status from the count
//   count      : current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_valid    : byte offered, accepted when wr_ready is also high
//   wr_data     : byte offered
//   wr_ready    : FIFO not full
//   txd         : registered serial output, idle high
//   busy        : FIFO non-empty or a frame in flight
//   tx_done     : high during the final clock of each stop bit
//   fifo_level  : FIFO occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             txd,
    output logic             busy,
    output logic             tx_done,
    output logic [LVL_W-1:0] fifo_level
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(CLK_DIV - 1);

    tx_state_e             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            data_q, data_d;
    logic                  txd_q, txd_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       pop;
    logic       baud_zero;
    logic [2:0] next_idx;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    // Derived from the registered count, so a same-cycle pop never frees a slot early.
    assign wr_ready  = !fifo_full;
    assign busy      = !fifo_empty || (state_q != StIdle);
    assign txd       = txd_q;
    assign baud_zero = (baud_q == '0);
    assign next_idx  = bit_idx_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        tx_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_rd_data;
                    state_d = StStart;
                    txd_d   = 1'b0;
                    baud_d  = BAUD_RELOAD;
                end
            end
            StStart: begin
                if (baud_zero) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    txd_d     = data_q[0];
                    baud_d    = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StData: begin
                if (baud_zero) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = next_idx;  // 7 wraps to 0 on the way into STOP
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d = data_q[next_idx];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StStop: begin
                if (baud_zero) begin
                    tx_done = 1'b1;
                    // Chain straight into the next start bit so frames are gapless.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rd_data;
                        state_d = StStart;
                        txd_d   = 1'b0;
                        baud_d  = BAUD_RELOAD;
                    end else begin
                        state_d = StIdle;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// A serial monitor decodes frames at mid-bit; decoded bytes are compared against
// a scoreboard queue filled as bytes are written.
module tb_uart_tx_fifo;

    localparam int CLK_DIV    = 217;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME      = 10 * CLK_DIV;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             wr_valid = 1'b0;
    logic [7:0]       wr_data  = 8'h00;
    logic             wr_ready;
    logic             txd;
    logic             busy;
    logic             tx_done;
    logic [LVL_W-1:0] fifo_level;

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done) done_cnt <= done_cnt + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       start_bit;
        logic       stop_bit;
    } rx_t;

    typedef struct {
        logic [7:0]       data;
        bit               acc;
        logic [LVL_W-1:0] lvl;
        logic             rdy;
        logic             txd;
        logic             busy;
    } vec_t;

    rx_t        rx_q[$];
    int         start_q[$];
    logic [7:0] sb[$];
    bit         mon_en = 1'b1;
    vec_t       vecs[6];
    logic [7:0] msg[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial monitor: falling edge seen at a negedge, then samples at mid-bit.
    initial begin : monitor
        logic prev;
        rx_t  r;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !txd) begin
                start_q.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge clk);
                r.start_bit = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    r.data[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                r.stop_bit = txd;
                rx_q.push_back(r);
            end
            prev = txd;
        end
    end

    task automatic score();
        rx_t        r;
        logic [7:0] e;
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            check("rx start bit", 32'(r.start_bit), 0);
            check("rx stop bit", 32'(r.stop_bit), 1);
            if (sb.size() == 0) begin
                check("rx unexpected frame", 32'(r.data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("rx byte", 32'(r.data), 32'(e));
            end
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        forever begin
            score();
            if ((sb.size() == 0 && !busy) || n >= 6 * FRAME) break;
            @(negedge clk);
            n++;
        end
        check("drain scoreboard empty", sb.size(), 0);
        check("drain busy low", 32'(busy), 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input bit track);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) check("send wr_ready timeout", 32'(wr_ready), 1);
        else if (track) sb.push_back(d);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int n;
        int base;
        int lows;
        int busies;

        vecs[0] = '{8'h41, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h42, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h43, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h44, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h45, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h46, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
        msg = '{8'h4F, 8'h4B, 8'h0A, 8'h43, 8'h31, 8'h53, 8'h31, 8'h54, 8'h31, 8'h44, 8'h4E};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd), 1);
        check("reset wr_ready", 32'(wr_ready), 1);
        check("reset busy", 32'(busy), 0);
        check("reset tx_done", 32'(tx_done), 0);
        check("reset fifo_level", 32'(fifo_level), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle txd", 32'(txd), 1);

        // Single 0x55 frame: bit timing and tx_done position
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        sb.push_back(8'h55);
        @(negedge clk);
        k = cyc;
        wr_valid = 1'b0;
        check("t1 txd at accept", 32'(txd), 1);
        check("t1 busy", 32'(busy), 1);
        check("t1 level", 32'(fifo_level), 1);
        for (int j = 0; j < 10; j++) begin
            wait_cyc(k + 1 + j * CLK_DIV);
            check("t1 bit first clock", 32'(txd), 32'(j % 2));
            check("t1 tx_done early", 32'(tx_done), 0);
            wait_cyc(k + (j + 1) * CLK_DIV);
            check("t1 bit last clock", 32'(txd), 32'(j % 2));
        end
        check("t1 tx_done pulse", 32'(tx_done), 1);
        wait_cyc(k + FRAME + 1);
        check("t1 tx_done cleared", 32'(tx_done), 0);
        check("t1 busy cleared", 32'(busy), 0);
        check("t1 txd idle", 32'(txd), 1);
        wait_drain();

        // "OK\n" back to back
        base = done_cnt;
        start_q.delete();
        send(8'h4F, 1'b1);
        send(8'h4B, 1'b1);
        send(8'h0A, 1'b1);
        wait_drain();
        check("t2 tx_done pulses", done_cnt - base, 3);
        check("t2 frames seen", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("t2 gap 1", start_q[1] - start_q[0], FRAME);
            check("t2 gap 2", start_q[2] - start_q[1], FRAME);
        end

        // Table: six write attempts from idle with depth 4
        k = 0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = vecs[i].data;
            if (vecs[i].acc) sb.push_back(vecs[i].data);
            @(negedge clk);
            if (i == 0) k = cyc;
            check("t3 level", 32'(fifo_level), 32'(vecs[i].lvl));
            check("t3 wr_ready", 32'(wr_ready), 32'(vecs[i].rdy));
            check("t3 txd", 32'(txd), 32'(vecs[i].txd));
            check("t3 busy", 32'(busy), 32'(vecs[i].busy));
        end
        n = 0;
        while (!tx_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t3 first tx_done cycle", cyc, k + FRAME);
        check("t3 wr_ready during pop", 32'(wr_ready), 0);
        check("t3 level during pop", 32'(fifo_level), 4);
        @(negedge clk);
        check("t3 wr_ready after pop", 32'(wr_ready), 1);
        check("t3 level after pop", 32'(fifo_level), 3);
        sb.push_back(8'h46);
        @(negedge clk);
        wr_valid = 1'b0;
        check("t3 sixth accepted", 32'(fifo_level), 4);
        wait_drain();

        // Push and pop on the same edge at level 2, 11-byte ordering
        send(msg[0], 1'b1);
        send(msg[1], 1'b1);
        send(msg[2], 1'b1);
        check("t4 level before", 32'(fifo_level), 2);
        n = 0;
        while (!tx_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t4 tx_done seen", 32'(tx_done), 1);
        check("t4 level at pop", 32'(fifo_level), 2);
        wr_valid = 1'b1;
        wr_data  = msg[3];
        sb.push_back(msg[3]);
        @(negedge clk);
        wr_valid = 1'b0;
        check("t4 level push+pop", 32'(fifo_level), 2);
        for (int i = 4; i < 11; i++) send(msg[i], 1'b1);
        wait_drain();

        // Reset mid-frame with two bytes queued
        mon_en = 1'b0;
        send(8'h0F, 1'b0);
        k = cyc;
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b0);
        wait_cyc(k + 1 + 5 * CLK_DIV + CLK_DIV / 2);
        check("t5 level before reset", 32'(fifo_level), 2);
        check("t5 txd at bit 4", 32'(txd), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5 reset txd", 32'(txd), 1);
        check("t5 reset level", 32'(fifo_level), 0);
        check("t5 reset wr_ready", 32'(wr_ready), 1);
        check("t5 reset busy", 32'(busy), 0);
        check("t5 reset tx_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows   = 0;
        busies = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        check("t5 txd low after release", lows, 0);
        check("t5 busy after release", busies, 0);
        check("t5 level after release", 32'(fifo_level), 0);
        mon_en = 1'b1;
        send(8'h5A, 1'b1);
        check("t5 txd at accept", 32'(txd), 1);
        @(negedge clk);
        check("t5 txd start bit", 32'(txd), 0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
